// File: rtl/gate_chk_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
//   Shared definitions for the gate vector sequencer.
//   - chk_state_t : sequencer FSM states
//   - NUM_VECTORS : number of {A,B} input combinations applied per run
//   - EXP_*       : expected-Y truth tables, bit[idx] = expected Y for vector idx
//   - vec_is_last : true when idx is the final vector of a run
// -----------------------------------------------------------------------------
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } chk_state_t;

    localparam int NUM_VECTORS = 4;

    localparam logic [3:0] EXP_AND  = 4'b1000;
    localparam logic [3:0] EXP_OR   = 4'b1110;
    localparam logic [3:0] EXP_NAND = 4'b0111;
    localparam logic [3:0] EXP_NOR  = 4'b0001;
    localparam logic [3:0] EXP_XOR  = 4'b0110;
    localparam logic [3:0] EXP_XNOR = 4'b1001;

    function automatic logic vec_is_last(input logic [1:0] idx);
        return idx == 2'(NUM_VECTORS - 1);
    endfunction

endpackage

// File: rtl/gate_hold_timer.sv
// -----------------------------------------------------------------------------
// gate_hold_timer
//   Loadable down-counter that measures how long a vector is held on the gate.
//   Ports:
//     clk     in          rising-edge clock
//     rst     in          synchronous active-high reset (count -> 0)
//     load    in          load 'value' into the counter (has priority over en)
//     en      in          decrement by one while the count is non-zero
//     value   in  CNT_W   reload value
//     expired out         count == 0
// -----------------------------------------------------------------------------
module gate_hold_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// -----------------------------------------------------------------------------
// gate_vector_sequencer
//   Drives a 2-input gate through all four {A,B} combinations, holds each one
//   for HOLD_CYCLES cycles, samples Y for one cycle and compares it with the
//   EXPECT truth table. Reports per-vector failures, an error count and a
//   pass/done status.
//   Ports:
//     clk        in      rising-edge clock
//     rst        in      synchronous active-high reset, abandons any run
//     start      in      pulse; starts a run from IDLE or DONE, ignored when busy
//     a_out      out     gate input A (= idx[1])
//     b_out      out     gate input B (= idx[0])
//     y_in       in      gate output Y, only looked at in SAMPLE
//     busy       out     run in progress (APPLY or SAMPLE)
//     done       out     run finished, held until next start or rst
//     pass       out     with done: no vector mismatched
//     err_count  out 3   mismatching vectors in current/last run (0..4)
//     fail_vec   out 4   bit[idx] set when vector idx mismatched
// -----------------------------------------------------------------------------
module gate_vector_sequencer
    import gate_chk_pkg::*;
#(
    parameter int         HOLD_CYCLES = 10,
    parameter int         CNT_W       = 4,
    parameter logic [3:0] EXPECT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_hold
        $error("gate_vector_sequencer: HOLD_CYCLES=%0d out of range for CNT_W=%0d",
               HOLD_CYCLES, CNT_W);
    end

    // The timer counts HOLD_CYCLES-1 down to 0, so APPLY spans HOLD_CYCLES cycles.
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    chk_state_t state_q, state_n;
    logic [1:0] idx_q,   idx_n;
    logic [2:0] err_q,   err_n;
    logic [3:0] fail_q,  fail_n;
    logic       pass_q,  pass_n;

    logic tmr_load;
    logic tmr_en;
    logic tmr_expired;
    logic mismatch;

    gate_hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .value   (HOLD_RELOAD),
        .expired (tmr_expired)
    );

    assign mismatch = (y_in != EXPECT[idx_q]);

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        err_n    = err_q;
        fail_n   = fail_q;
        pass_n   = pass_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n  = ST_APPLY;
                    idx_n    = 2'd0;
                    err_n    = 3'd0;
                    fail_n   = 4'd0;
                    pass_n   = 1'b0;
                    tmr_load = 1'b1;
                end
            end

            ST_APPLY: begin
                if (tmr_expired) begin
                    state_n = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_n         = err_q + 3'd1;
                    fail_n[idx_q] = 1'b1;
                end
                if (vec_is_last(idx_q)) begin
                    state_n = ST_DONE;
                    // err_n already includes this cycle's comparison.
                    pass_n  = (err_n == 3'd0);
                end else begin
                    state_n  = ST_APPLY;
                    idx_n    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            err_q   <= err_n;
            fail_q  <= fail_n;
            pass_q  <= pass_n;
        end
    end

    // idx stays at the last vector in DONE, so the gate keeps seeing (1,1).
    assign a_out     = idx_q[1];
    assign b_out     = idx_q[0];
    assign busy      = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
